// File: rtl/psram_qspi_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : psram_qspi_target                                             |
// | Function : QSPI/QPI PSRAM responder backed by an internal byte array.    |
// |            Decodes command / address / wait / data phases issued by a    |
// |            PSRAM controller and serves reads and writes.                 |
// | Options  : PSRAM_TGT_QPI_EN - enables 0x35/0xF5 and QPI mode.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module psram_qspi_target #(
   parameter int DEPTH       = 4096,
   parameter int AW          = 12,
   parameter int WAIT_CYCLES = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ce_n,
   input  logic [3:0] si,
   output logic [3:0] so,
   output logic [3:0] so_en,
   output logic       qpi_mode,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RDATA  = 3'd4,
      ST_WDATA  = 3'd5,
      ST_IGNORE = 3'd6
   } state_t;

   localparam logic [7:0] c_cmd_read    = 8'h03;
   localparam logic [7:0] c_cmd_fread   = 8'h0B;
   localparam logic [7:0] c_cmd_write   = 8'h02;
   localparam logic [7:0] c_cmd_qread   = 8'hEB;
   localparam logic [7:0] c_cmd_qwrite  = 8'h38;
`ifdef PSRAM_TGT_QPI_EN
   localparam logic [7:0] c_cmd_qpi_on  = 8'h35;
   localparam logic [7:0] c_cmd_qpi_off = 8'hF5;
`endif

   // Synchronizers plus one history flop each for edge detection
   logic          sck_meta_q, sck_sync_q, sck_prev_q;
   logic          ce_meta_q, ce_sync_q, ce_prev_q;
   logic [3:0]    si_meta_q, si_sync_q;
   logic          sck_rise, sck_fall, ce_fall;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    sh_q, sh_d;
   logic          quad_addr_q, quad_addr_d;
   logic          quad_data_q, quad_data_d;
   logic          rd_q, rd_d;
   logic [7:0]    wlen_q, wlen_d;
   logic [3:0]    so_q, so_d;
   logic [3:0]    so_en_q, so_en_d;
   logic          busy_q, busy_d;
   logic          qpi_act;

`ifdef PSRAM_TGT_QPI_EN
   logic          qpi_q, qpi_d;
   logic          pend_q, pend_d;
   logic          qpi_next_q, qpi_next_d;
   assign qpi_act = qpi_q;
`else
   assign qpi_act = 1'b0;
`endif

   logic [7:0]    mem_q [DEPTH];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   logic [7:0]    cmd_v, cmd_e, byte_v;
   logic [AW-1:0] addr_v, addr_inc;
   logic          done;

   assign sck_rise = sck_sync_q & ~sck_prev_q;
   assign sck_fall = ~sck_sync_q & sck_prev_q;
   // ce sync flops reset low so a ce_n held low across reset is not seen as a new falling edge
   assign ce_fall  = ~ce_sync_q & ce_prev_q;
   assign addr_inc = addr_q + AW'(1);

   // Next-state and datapath decode, one sck edge at a time; ce_n high overrides everything
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      sh_d        = sh_q;
      quad_addr_d = quad_addr_q;
      quad_data_d = quad_data_q;
      rd_d        = rd_q;
      wlen_d      = wlen_q;
      so_d        = so_q;
      so_en_d     = so_en_q;
      wr_en       = 1'b0;
      wr_addr     = addr_q;
      wr_data     = sh_q;
      cmd_v       = cmd_q;
      cmd_e       = cmd_q;
      addr_v      = addr_q;
      byte_v      = sh_q;
      done        = 1'b0;
`ifdef PSRAM_TGT_QPI_EN
      qpi_d       = qpi_q;
      pend_d      = pend_q;
      qpi_next_d  = qpi_next_q;
`endif
      if (ce_sync_q) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         so_d    = '0;
         so_en_d = '0;
`ifdef PSRAM_TGT_QPI_EN
         if (pend_q) begin
            qpi_d  = qpi_next_q;
            pend_d = 1'b0;
         end
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ce_fall) begin
                  state_d = ST_CMD;
                  cnt_d   = '0;
                  cmd_d   = '0;
               end
            end
            ST_CMD: begin
               if (sck_rise) begin
                  if (qpi_act) begin
                     cmd_v = {cmd_q[3:0], si_sync_q};
                     done  = (cnt_q == 8'd1);
                  end else begin
                     cmd_v = {cmd_q[6:0], si_sync_q[0]};
                     done  = (cnt_q == 8'd7);
                  end
                  cmd_d = cmd_v;
                  cnt_d = cnt_q + 8'd1;
                  if (done) begin
                     cnt_d = '0;
                     cmd_e = cmd_v;
                     // In QPI mode the single-lane read/write opcodes map onto the quad ones
                     if (qpi_act && cmd_v == c_cmd_read)  cmd_e = c_cmd_qread;
                     if (qpi_act && cmd_v == c_cmd_write) cmd_e = c_cmd_qwrite;
                     case (cmd_e)
                        c_cmd_read: begin
                           state_d = ST_ADDR; quad_addr_d = qpi_act; quad_data_d = qpi_act;
                           rd_d = 1'b1; wlen_d = 8'd0;
                        end
                        c_cmd_fread: begin
                           state_d = ST_ADDR; quad_addr_d = qpi_act; quad_data_d = qpi_act;
                           rd_d = 1'b1; wlen_d = 8'd8;
                        end
                        c_cmd_write: begin
                           state_d = ST_ADDR; quad_addr_d = qpi_act; quad_data_d = qpi_act;
                           rd_d = 1'b0; wlen_d = 8'd0;
                        end
                        c_cmd_qread: begin
                           state_d = ST_ADDR; quad_addr_d = 1'b1; quad_data_d = 1'b1;
                           rd_d = 1'b1; wlen_d = 8'(WAIT_CYCLES);
                        end
                        c_cmd_qwrite: begin
                           state_d = ST_ADDR; quad_addr_d = 1'b1; quad_data_d = 1'b1;
                           rd_d = 1'b0; wlen_d = 8'd0;
                        end
`ifdef PSRAM_TGT_QPI_EN
                        c_cmd_qpi_on: begin
                           state_d = ST_IDLE; pend_d = 1'b1; qpi_next_d = 1'b1;
                        end
                        c_cmd_qpi_off: begin
                           state_d = ST_IDLE; pend_d = 1'b1; qpi_next_d = 1'b0;
                        end
`endif
                        default: state_d = ST_IGNORE;
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (sck_rise) begin
                  // Only the low AW bits are kept; upper address bits fall off the top
                  if (quad_addr_q) begin
                     addr_v = {addr_q[AW-5:0], si_sync_q};
                     done   = (cnt_q == 8'd5);
                  end else begin
                     addr_v = {addr_q[AW-2:0], si_sync_q[0]};
                     done   = (cnt_q == 8'd23);
                  end
                  addr_d = addr_v;
                  cnt_d  = cnt_q + 8'd1;
                  if (done) begin
                     cnt_d = '0;
                     if (!rd_q) begin
                        state_d = ST_WDATA;
                     end else if (wlen_q != 8'd0) begin
                        state_d = ST_WAIT;
                     end else begin
                        state_d = ST_RDATA;
                        sh_d    = mem_q[addr_v];
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (sck_rise) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == wlen_q - 8'd1) begin
                     cnt_d   = '0;
                     state_d = ST_RDATA;
                     sh_d    = mem_q[addr_q];
                  end
               end
            end
            ST_RDATA: begin
               // Shift out on the falling edge so data is stable for the next rising edge
               if (sck_fall) begin
                  cnt_d = cnt_q + 8'd1;
                  if (quad_data_q) begin
                     so_en_d = 4'hF;
                     so_d    = sh_q[7:4];
                     sh_d    = {sh_q[3:0], 4'h0};
                     done    = (cnt_q == 8'd1);
                  end else begin
                     so_en_d = 4'b0010;
                     so_d    = {2'b00, sh_q[7], 1'b0};
                     sh_d    = {sh_q[6:0], 1'b0};
                     done    = (cnt_q == 8'd7);
                  end
                  if (done) begin
                     cnt_d  = '0;
                     addr_d = addr_inc;
                     sh_d   = mem_q[addr_inc];
                  end
               end
            end
            ST_WDATA: begin
               if (sck_rise) begin
                  if (quad_data_q) begin
                     byte_v = {sh_q[3:0], si_sync_q};
                     done   = (cnt_q == 8'd1);
                  end else begin
                     byte_v = {sh_q[6:0], si_sync_q[0]};
                     done   = (cnt_q == 8'd7);
                  end
                  sh_d  = byte_v;
                  cnt_d = cnt_q + 8'd1;
                  if (done) begin
                     cnt_d   = '0;
                     wr_en   = 1'b1;
                     wr_addr = addr_q;
                     wr_data = byte_v;
                     addr_d  = addr_inc;
                  end
               end
            end
            ST_IGNORE: begin
               so_en_d = '0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = !ce_sync_q && (state_d != ST_IDLE);
   end

   // Control state, synchronizers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_meta_q  <= 1'b0;
         sck_sync_q  <= 1'b0;
         sck_prev_q  <= 1'b0;
         ce_meta_q   <= 1'b0;
         ce_sync_q   <= 1'b0;
         ce_prev_q   <= 1'b0;
         si_meta_q   <= '0;
         si_sync_q   <= '0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         addr_q      <= '0;
         sh_q        <= '0;
         quad_addr_q <= 1'b0;
         quad_data_q <= 1'b0;
         rd_q        <= 1'b0;
         wlen_q      <= '0;
         so_q        <= '0;
         so_en_q     <= '0;
         busy_q      <= 1'b0;
`ifdef PSRAM_TGT_QPI_EN
         qpi_q       <= 1'b0;
         pend_q      <= 1'b0;
         qpi_next_q  <= 1'b0;
`endif
      end else begin
         sck_meta_q  <= sck;
         sck_sync_q  <= sck_meta_q;
         sck_prev_q  <= sck_sync_q;
         ce_meta_q   <= ce_n;
         ce_sync_q   <= ce_meta_q;
         ce_prev_q   <= ce_sync_q;
         si_meta_q   <= si;
         si_sync_q   <= si_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         sh_q        <= sh_d;
         quad_addr_q <= quad_addr_d;
         quad_data_q <= quad_data_d;
         rd_q        <= rd_d;
         wlen_q      <= wlen_d;
         so_q        <= so_d;
         so_en_q     <= so_en_d;
         busy_q      <= busy_d;
`ifdef PSRAM_TGT_QPI_EN
         qpi_q       <= qpi_d;
         pend_q      <= pend_d;
         qpi_next_q  <= qpi_next_d;
`endif
      end
   end

   // Backing store; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign so       = so_q;
   assign so_en    = so_en_q;
   assign busy     = busy_q;
   assign qpi_mode = qpi_act;

endmodule
`default_nettype wire

// File: doc/psram_qspi_target.md
# psram_qspi_target

Synthesizable QSPI/QPI PSRAM responder that emulates an external PSRAM device on the controller's quad I/O pins. The block is the far end of the PSRAM controller's serial link and is backed by an internal byte array. It decodes the command, address, wait and data phases that the controller issues, and serves reads and writes. It is used in FPGA prototypes and system testbenches in place of a real PSRAM part.

## Interface
- `DEPTH`, default 4096: memory size in bytes; must be a power of two.
- `AW`, default 12: stored address bits, equal to log2(DEPTH). Higher bits of the 24-bit address are ignored.
- `WAIT_CYCLES`, default 6: dummy sck cycles for quad read `0xEB`.
- `clk` input 1: system clock; must run at least 4x the sck frequency.
- `rst` input 1: asynchronous, active-high reset.
- `sck` input 1: serial clock from the controller; idles low (SPI mode 0).
- `ce_n` input 1: chip enable, active low.
- `si` input 4: controller data out. In SPI mode only `si[0]` is used.
- `so` output 4: target data out. In SPI mode only `so[1]` is used.
- `so_en` output 4: per-lane output enable.
- `qpi_mode` output 1: high while the target is in QPI mode.
- `busy` output 1: high while ce_n is low and the target is not in IDLE.

## Operation
- **Input synchronizing:** `sck`, `ce_n` and `si` pass through a 2-flop synchronizer.
  - Rising and falling sck edges are detected in the `clk` domain.
  - `si` is sampled on the detected rising edge.
  - `so` is updated on the detected falling edge.
- **States and transitions:**
  - IDLE to CMD on ce_n falling.
  - CMD to ADDR, or to IDLE for the QPI-toggle commands.
  - ADDR to WAIT, RDATA or WDATA.
  - WAIT to RDATA.
  - Any unknown command goes to IGNORE.
  - ce_n high returns the target to IDLE from any state.
- **Command phase:** 8 bits, MSB first.
  - SPI mode: 1 bit per clock on `si[0]`.
  - QPI mode: 1 nibble per clock on `si[3:0]`.
- **Commands:**
  - `0x03` read: address on 1 lane, no wait.
  - `0x0B` fast read: address on 1 lane, 8 wait clocks.
  - `0x02` write: address on 1 lane.
  - `0xEB` quad read: address on 4 lanes, WAIT_CYCLES wait clocks.
  - `0x38` quad write: address on 4 lanes.
  - `0x35` enter QPI; `0xF5` exit QPI.
- **QPI mode:** every phase uses 4 lanes. `0x03` and `0x02` are treated as `0xEB` and `0x38`.
- **Address phase:** 24 bits, MSB first, loaded into a counter. Only the low AW bits are used.
- **Data phase:**
  - Bytes go MSB first: high nibble, then low nibble, in quad.
  - The address increments after each byte and wraps from DEPTH-1 to 0.
- **Writes:** a byte is committed to the array only after all 8 bits have been received.
- **Reads:**
  - The byte at the current address is loaded into a shift register when the data phase starts and after each byte completes.
  - SPI reads: `so_en = 4'b0010`. Quad reads: `so_en = 4'hF`. All other times: `so_en = 0`.
- **IGNORE state:** the target drives nothing until ce_n goes high.

## Timing
- **Reset values:** `so=0`, `so_en=0`, `qpi_mode=0`, `busy=0`, state IDLE, address 0. The memory array is not reset.
- **Input latency:** an sck edge is recognised 2–3 `clk` cycles after it occurs on the pin.
- **Output latency:**
  - `so` changes within 3 `clk` cycles of sck falling.
  - The first read nibble is valid before the first data-phase rising edge.
  - Condition: the last address or wait clock has a falling edge followed by at least 2 `clk` cycles.
- **ce_n rising:**
  - `so_en` goes to 0 and the state goes to IDLE within 3 `clk` cycles.
  - A partial write byte is discarded; completed bytes remain.
- **Simultaneous events:** if a ce_n rise and an sck edge are seen in the same `clk` cycle, the ce_n rise takes priority and the sck edge is ignored.
- **Mode change:** `qpi_mode` toggles when ce_n rises after a complete `0x35` or `0xF5` command.
- **Reset mid-transaction:** the target returns immediately to reset values and ignores sck until the next ce_n falling edge.

## Configuration
- `PSRAM_TGT_QPI_EN`
  - Defined: `0x35` and `0xF5` are decoded and QPI mode is supported.
  - Undefined: `0x35` and `0xF5` go to IGNORE, `qpi_mode` is tied to 0, and the QPI phase logic is removed.

## Test plan
- Reset -> all outputs 0. SPI `0x02` to addr `0x000010` with data `A5 5A`, then `0x03` read of the same address -> `so[1]` returns `A5 5A`, and `so_en=4'b0010` during the data phase only.
- `0x38` to addr `0x000100` with data `12 34 56 78`, then `0xEB` read (6 wait clocks) -> `12 34 56 78` on 4 lanes, and `so_en=4'hF` starting at the first data clock.
- `0x35` (macro defined) -> `qpi_mode=1`. In QPI mode, `0xEB` read of `0x000100` -> `12`. Then `0xF5` -> `qpi_mode=0`.
- Write `AA BB` at address DEPTH-1 -> `mem[DEPTH-1]=AA` and `mem[0]=BB`. A read of DEPTH-1 returns `AA BB`.
- `0x02` to addr 0 with data `C3`, then 4 more bits, then ce_n high -> `mem[0]=C3`, `mem[1]` unchanged, `busy=0` within 3 `clk` cycles.
- Command `0x9F` -> `so_en` stays 0 through 32 sck clocks, and the state returns to IDLE after ce_n goes high.
